// File: rtl/prime_checker_seq.sv
// Sequential trial-division primality tester: start/done handshake, reports smallest nontrivial factor.
// Optional build macro PRIME_WHEEL6_EN walks candidate divisors along the 6k+/-1 wheel instead of all odds.
module prime_checker_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic [WIDTH-1:0] factor
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, SMALL, SQCHK, DIV, NEXT, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             is_prime_q, is_prime_d;
  logic [WIDTH-1:0] factor_q, factor_d;
`ifdef PRIME_WHEEL6_EN
  logic             step4_q, step4_d;
`endif

  logic [2*WIDTH-1:0] sq;
  logic               sq_gt_n;
  logic [CW-1:0]      bit_idx;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     rem_next;
  logic               n_ge2;
  logic               n_mod3_zero;
  logic [WIDTH-1:0]   step;

  // Squaring at double width means d*d never wraps, so the stop test is exact.
  assign sq       = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
  assign sq_gt_n  = sq > {{WIDTH{1'b0}}, n_q};

  // One restoring-division step: bring down the next operand bit, subtract d if it fits.
  assign bit_idx  = CW'(WIDTH - 1) - cnt_q;
  assign shifted  = {rem_q[WIDTH-1:0], n_q[bit_idx]};
  assign trial    = shifted - {1'b0, d_q};
  assign rem_next = (shifted >= {1'b0, d_q}) ? trial : shifted;

  assign n_ge2       = n_q >= WIDTH'(2);
  assign n_mod3_zero = (n_q % WIDTH'(3)) == '0;

`ifdef PRIME_WHEEL6_EN
  assign step = step4_q ? WIDTH'(4) : WIDTH'(2);
`else
  assign step = WIDTH'(2);
`endif

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    d_d        = d_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    is_prime_d = is_prime_q;
    factor_d   = factor_q;
`ifdef PRIME_WHEEL6_EN
    step4_d    = step4_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = num;
          busy_d  = 1'b1;
          state_d = SMALL;
        end
      end
      SMALL: begin
        // Assume a trivial verdict; only the undecided case falls through to trial division.
        state_d    = FIN;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        is_prime_d = 1'b0;
        factor_d   = '0;
        if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
          is_prime_d = 1'b1;
        end else if (n_ge2 && !n_q[0]) begin
          factor_d = WIDTH'(2);
        end else if (n_ge2 && n_mod3_zero) begin
          factor_d = WIDTH'(3);
        end else if (n_ge2) begin
          state_d    = SQCHK;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          is_prime_d = is_prime_q;
          factor_d   = factor_q;
          d_d        = WIDTH'(5);
`ifdef PRIME_WHEEL6_EN
          step4_d    = 1'b0;
`endif
        end
      end
      SQCHK: begin
        if (sq_gt_n) begin
          state_d    = FIN;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          is_prime_d = 1'b1;
          factor_d   = '0;
        end else begin
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (rem_q == '0) begin
          state_d    = FIN;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          is_prime_d = 1'b0;
          factor_d   = d_q;
        end else begin
          d_d     = d_q + step;
`ifdef PRIME_WHEEL6_EN
          step4_d = ~step4_q;
`endif
          state_d = SQCHK;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      d_q        <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      is_prime_q <= 1'b0;
      factor_q   <= '0;
`ifdef PRIME_WHEEL6_EN
      step4_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      d_q        <= d_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      is_prime_q <= is_prime_d;
      factor_q   <= factor_d;
`ifdef PRIME_WHEEL6_EN
      step4_q    <= step4_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign is_prime = is_prime_q;
  assign factor   = factor_q;

endmodule
